// File: rtl/branch_pkg.sv
// Shared types and helpers for the bimodal branch predictor.
package branch_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    localparam bht_state_t BHT_INIT = WNT;

    // Saturating step of a 2-bit counter toward the resolved outcome.
    function automatic bht_state_t bht_next(bht_state_t s, logic taken);
        bht_state_t n;
        n = s;
        if (taken) begin
            case (s)
                SNT:     n = WNT;
                WNT:     n = WT;
                default: n = ST;
            endcase
        end else begin
            case (s)
                ST:      n = WT;
                WT:      n = WNT;
                default: n = SNT;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// ID lookup, EX resolve and redirect/statistics signals of the branch predictor.
interface branch_predict_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] id_pc;
    logic             id_pred_taken;
    logic             ex_valid;
    logic             ex_branch;
    logic             ex_stall;
    logic [WIDTH-1:0] ex_pc;
    logic             ex_pred_taken;
    logic             ex_taken;
    logic [WIDTH-1:0] ex_target;
    logic             bht_clear;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             flush;
    logic [31:0]      branch_count;
    logic [31:0]      mispredict_count;

    // Pipeline side: presents PCs and resolved outcomes, consumes redirects.
    modport master (
        output id_pc, ex_valid, ex_branch, ex_stall, ex_pc, ex_pred_taken,
               ex_taken, ex_target, bht_clear,
        input  id_pred_taken, redirect, redirect_pc, flush,
               branch_count, mispredict_count
    );

    // Predictor side.
    modport slave (
        input  id_pc, ex_valid, ex_branch, ex_stall, ex_pc, ex_pred_taken,
               ex_taken, ex_target, bht_clear,
        output id_pred_taken, redirect, redirect_pc, flush,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_sat_counter.sv
// One 2-bit saturating counter of the branch history table.
module branch_sat_counter
    import branch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       taken,
    output bht_state_t state
);

    bht_state_t r_state;

    // Counter state: clear has priority over a training step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BHT_INIT;
        end else if (clear) begin
            r_state <= BHT_INIT;
        end else if (en) begin
            r_state <= bht_next(r_state, taken);
        end
    end

    assign state = r_state;

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: counter table lookup for ID, training,
// misprediction redirect/flush and branch statistics for EX.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_predict_unit_if.slave bus
);

    localparam int IDX = $clog2(ENTRIES);

    bht_state_t       w_state [ENTRIES];
    logic [ENTRIES-1:0] w_en;
    logic [IDX-1:0]   w_lk_idx;
    logic [IDX-1:0]   w_upd_idx;
    logic             w_res;
    logic             w_mispredict;
    logic [WIDTH-1:0] w_pc_plus4;
    bht_state_t       w_lk_state;
    logic             w_unused_bits;

    logic [31:0]      r_branch_count;
    logic [31:0]      r_mispredict_count;

    assign w_lk_idx     = bus.id_pc[IDX+1:2];
    assign w_upd_idx    = bus.ex_pc[IDX+1:2];
    assign w_res        = bus.ex_valid & bus.ex_branch & ~bus.ex_stall;
    assign w_mispredict = bus.ex_valid & bus.ex_branch & (bus.ex_taken != bus.ex_pred_taken);
    assign w_pc_plus4   = bus.ex_pc + WIDTH'(4);

    // Alias bits above the index and byte-offset bits play no part in lookup.
    assign w_unused_bits = ^{bus.id_pc[WIDTH-1:IDX+2], bus.id_pc[1:0], bus.ex_pc[1:0]};

    // Update decode: one-hot enable for the entry addressed by ex_pc.
    always_comb begin
        w_en = '0;
        if (w_res) begin
            w_en[w_upd_idx] = 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < ENTRIES; g++) begin : g_bht
            branch_sat_counter u_ctr (
                .clk   (clk),
                .reset (reset),
                .clear (bus.bht_clear),
                .en    (w_en[g]),
                .taken (bus.ex_taken),
                .state (w_state[g])
            );
        end
    endgenerate

    // Lookup mux: reads registered state, so a same-cycle update is not bypassed.
    always_comb begin
        w_lk_state        = w_state[w_lk_idx];
        bus.id_pred_taken = (w_lk_state == WT) || (w_lk_state == ST);
    end

    // Redirect: fall-through address unless a taken branch was mispredicted.
    always_comb begin
        bus.redirect    = w_mispredict;
        bus.flush       = w_mispredict;
        bus.redirect_pc = w_pc_plus4;
        if (w_mispredict && bus.ex_taken) begin
            bus.redirect_pc = bus.ex_target;
        end
    end

    // Statistics: counted once per unstalled resolve; clear wins over counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (bus.bht_clear) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_res) begin
            r_branch_count <= r_branch_count + 32'd1;
            if (bus.ex_taken != bus.ex_pred_taken) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

    assign bus.branch_count     = r_branch_count;
    assign bus.mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit (WIDTH=32, ENTRIES=64).
module tb_branch_predict_unit;

    typedef struct packed {
        logic        red;
        logic [31:0] pc;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    exp_t       sb[$];
    logic [1:0] mdl [64];
    logic [31:0] mdl_br;
    logic [31:0] mdl_mp;

    branch_predict_unit_if #(.WIDTH(32)) bus ();

    branch_predict_unit #(.WIDTH(32), .ENTRIES(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] idx(input logic [31:0] pc);
        return pc[7:2];
    endfunction

    function automatic logic [1:0] mdl_step(input logic [1:0] s, input logic t);
        if (t) return (s == 2'd3) ? 2'd3 : s + 2'd1;
        else   return (s == 2'd0) ? 2'd0 : s - 2'd1;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 64; i++) mdl[i] = 2'b01;
        mdl_br = '0;
        mdl_mp = '0;
    endtask

    task automatic idle_ex();
        bus.ex_valid      = 1'b0;
        bus.ex_branch     = 1'b0;
        bus.ex_stall      = 1'b0;
        bus.ex_pc         = '0;
        bus.ex_pred_taken = 1'b0;
        bus.ex_taken      = 1'b0;
        bus.ex_target     = '0;
        bus.bht_clear     = 1'b0;
    endtask

    // One EX cycle: drive, push expectation, compare combinational outputs,
    // then advance the model across the clock edge.
    task automatic step_branch(input string nm, input logic [31:0] pc, input logic pred,
                               input logic taken, input logic [31:0] tgt,
                               input logic stall, input logic clr, input logic br);
        exp_t e;
        exp_t g;
        logic exp_pred;
        @(negedge clk);
        bus.ex_valid      = 1'b1;
        bus.ex_branch     = br;
        bus.ex_stall      = stall;
        bus.ex_pc         = pc;
        bus.ex_pred_taken = pred;
        bus.ex_taken      = taken;
        bus.ex_target     = tgt;
        bus.bht_clear     = clr;
        bus.id_pc         = pc;
        e.red = br && (taken != pred);
        e.pc  = (e.red && taken) ? tgt : pc + 32'd4;
        sb.push_back(e);
        exp_pred = mdl[idx(pc)][1];
        #1;
        g = sb.pop_front();
        checks++;
        if (bus.redirect !== g.red) begin
            errors++;
            $display("FAIL %s redirect: got %b expected %b", nm, bus.redirect, g.red);
        end
        checks++;
        if (bus.flush !== g.red) begin
            errors++;
            $display("FAIL %s flush: got %b expected %b", nm, bus.flush, g.red);
        end
        checks++;
        if (bus.redirect_pc !== g.pc) begin
            errors++;
            $display("FAIL %s redirect_pc: got %h expected %h", nm, bus.redirect_pc, g.pc);
        end
        checks++;
        if (bus.id_pred_taken !== exp_pred) begin
            errors++;
            $display("FAIL %s rdw_pred: got %b expected %b", nm, bus.id_pred_taken, exp_pred);
        end
        @(posedge clk);
        if (clr) begin
            mdl_reset();
        end else if (br && !stall) begin
            mdl[idx(pc)] = mdl_step(mdl[idx(pc)], taken);
            mdl_br++;
            if (taken != pred) mdl_mp++;
        end
        #1;
        idle_ex();
    endtask

    task automatic check_pred(input string nm, input logic [31:0] pc, input logic exp);
        @(negedge clk);
        bus.id_pc = pc;
        #1;
        checks++;
        if (bus.id_pred_taken !== exp) begin
            errors++;
            $display("FAIL %s pred@%h: got %b expected %b", nm, pc, bus.id_pred_taken, exp);
        end
    endtask

    task automatic check_counts(input string nm);
        @(negedge clk);
        #1;
        checks++;
        if (bus.branch_count !== mdl_br) begin
            errors++;
            $display("FAIL %s branch_count: got %0d expected %0d", nm, bus.branch_count, mdl_br);
        end
        checks++;
        if (bus.mispredict_count !== mdl_mp) begin
            errors++;
            $display("FAIL %s mispredict_count: got %0d expected %0d", nm, bus.mispredict_count, mdl_mp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_ex();
        bus.id_pc = '0;
        mdl_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 64; i++) check_pred("reset", 32'(i * 4), 1'b0);
        check_counts("reset");
        checks++;
        if (bus.redirect !== 1'b0 || bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL reset idle_redirect: got %b/%b expected 0/0", bus.redirect, bus.flush);
        end
    endtask

    task automatic test_training();
        step_branch("train1", 32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1);
        check_pred("train_wt", 32'h40, 1'b1);
        step_branch("train2", 32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1);
        step_branch("train3", 32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1);
        step_branch("train_nt", 32'h40, 1'b1, 1'b0, 32'h80, 1'b0, 1'b0, 1'b1);
        check_pred("train_st_wt", 32'h40, 1'b1);
        check_counts("training");
    endtask

    task automatic test_aliasing();
        for (int i = 0; i < 3; i++)
            step_branch("alias", 32'h100, mdl[0][1], 1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
        check_pred("alias_200", 32'h200, 1'b1);
    endtask

    task automatic test_not_taken();
        step_branch("nt_ok", 32'h1234, 1'b0, 1'b0, 32'h5000, 1'b0, 1'b0, 1'b1);
        step_branch("nt_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h5000, 1'b0, 1'b0, 1'b1);
        step_branch("nonbranch", 32'h88, 1'b0, 1'b1, 32'h9000, 1'b0, 1'b0, 1'b0);
        check_counts("not_taken");
    endtask

    task automatic test_stall();
        logic [31:0] br0;
        logic [31:0] mp0;
        br0 = mdl_br;
        mp0 = mdl_mp;
        for (int i = 0; i < 3; i++)
            step_branch("stall_hold", 32'h60, 1'b0, 1'b1, 32'h700, 1'b1, 1'b0, 1'b1);
        check_counts("stall_held");
        step_branch("stall_rel", 32'h60, 1'b0, 1'b1, 32'h700, 1'b0, 1'b0, 1'b1);
        check_counts("stall_released");
        checks++;
        if (bus.branch_count !== br0 + 32'd1 || bus.mispredict_count !== mp0 + 32'd1) begin
            errors++;
            $display("FAIL stall_once counts: got %0d/%0d expected %0d/%0d",
                     bus.branch_count, bus.mispredict_count, br0 + 1, mp0 + 1);
        end
        check_pred("stall_wt", 32'h60, 1'b1);
        // A single step landed on WT, so one not-taken must drop to WNT.
        step_branch("stall_back", 32'h60, 1'b1, 1'b0, 32'h700, 1'b0, 1'b0, 1'b1);
        check_pred("stall_one_step", 32'h60, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc;
        logic        t;
        for (int i = 0; i < 12; i++) begin
            pc = {24'h0, 2'b00, 4'($urandom_range(0, 15)), 2'b00};
            t  = 1'($urandom_range(0, 1));
            step_branch("b2b", pc, mdl[idx(pc)][1], t, 32'h4000 + 32'(i * 16),
                        1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 16; i++) check_pred("b2b_table", 32'(i * 4), mdl[i][1]);
        check_counts("b2b");
    endtask

    task automatic test_clear_collision();
        step_branch("clr_pre", 32'h14, mdl[5][1], 1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
        step_branch("clr_pre", 32'h14, mdl[5][1], 1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
        check_pred("clr_trained", 32'h14, 1'b1);
        step_branch("clr_hit", 32'h14, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1);
        check_pred("clr_idx5", 32'h14, 1'b0);
        check_pred("clr_idx16", 32'h40, 1'b0);
        check_counts("clear");
        checks++;
        if (bus.branch_count !== 32'd0 || bus.mispredict_count !== 32'd0) begin
            errors++;
            $display("FAIL clear_zero counts: got %0d/%0d expected 0/0",
                     bus.branch_count, bus.mispredict_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_training();
        test_aliasing();
        test_not_taken();
        test_stall();
        test_back_to_back();
        test_clear_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Bimodal branch predictor and misprediction controller for the pipelined RV32I core. It holds a table of 2-bit saturating counters indexed by PC and supplies a taken/not-taken prediction to ID, where the branch target is formed. When EX resolves a conditional branch against the branch controller's `pc_sel`, it trains the table, detects mispredictions, and drives the PC redirect and the IF/ID, ID/EX flush.

## Interface
- `WIDTH`, default 32: address/data width.
- `ENTRIES`, default 64: counter-table depth. Power of two, 4 to 1024. `IDX = $clog2(ENTRIES)`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `id_pc` input WIDTH: PC of the instruction in ID.
- `id_pred_taken` output 1: prediction for `id_pc`.
- `ex_valid` input 1: EX holds a real (non-bubble) instruction.
- `ex_branch` input 1: EX instruction is a conditional branch.
- `ex_stall` input 1: EX is stalled this cycle, so training and statistics are suppressed.
- `ex_pc` input WIDTH: PC of the EX instruction.
- `ex_pred_taken` input 1: prediction piped from ID with the instruction.
- `ex_taken` input 1: resolved outcome (branch controller `pc_sel`).
- `ex_target` input WIDTH: resolved branch target.
- `bht_clear` input 1: synchronous reinitialisation of all counters.
- `redirect` output 1: PC must load `redirect_pc`.
- `redirect_pc` output WIDTH: corrected fetch address.
- `flush` output 1: squash IF/ID and ID/EX.
- `branch_count` output 32: resolved conditional branches.
- `mispredict_count` output 32: mispredicted branches.

## Operation
- Index is `pc[IDX+1:2]`. Bits [1:0] are ignored, and higher bits alias.
- Counter states are SNT=00, WNT=01, WT=10, ST=11. Prediction is taken when state is WT or ST.
- Transitions:
  - Taken: SNT→WNT→WT→ST, and ST stays ST.
  - Not taken: ST→WT→WNT→SNT, and SNT stays SNT.
- A resolve event is `res = ex_valid & ex_branch & ~ex_stall`.
- On `res`:
  - Update the entry at `ex_pc` with `ex_taken`.
  - Increment `branch_count`.
  - If `ex_taken != ex_pred_taken`, also increment `mispredict_count`.
- `mispredict = ex_valid & ex_branch & (ex_taken != ex_pred_taken)`. It is not gated by `ex_stall`.
- Redirect outputs:
  - `redirect = flush = mispredict`.
  - `redirect_pc = ex_taken ? ex_target : ex_pc + 4`, computed modulo 2^WIDTH.
  - `redirect_pc` is `ex_pc + 4` whenever `redirect` is low.
- Non-branch instructions (`ex_branch` = 0) never train, count, or redirect. `jal`/`jalr` are handled elsewhere.
- `bht_clear`:
  - Sets every counter to WNT and zeroes both statistics counters on the next edge.
  - If it coincides with `res`, the clear wins and the update is dropped.
- The statistics counters wrap modulo 2^32. There is no saturation.
- Reset:
  - All counters go to WNT.
  - `branch_count` and `mispredict_count` go to 0.
  - `id_pred_taken` therefore reads 0.
  - `redirect` and `flush` read 0 whenever the EX inputs are idle.

## Timing
- Lookup is combinational: `id_pred_taken` follows `id_pc` in the same cycle.
- Training has 1-cycle latency: the updated state is visible to lookups from the following cycle.
- Read-during-write: if the same index is looked up and updated in the same cycle, the lookup returns the pre-update state. There is no bypass.
- `redirect`, `flush` and `redirect_pc` are combinational from EX inputs in the same cycle. The PC register captures `redirect_pc` at the next edge.
- While `ex_stall` is held, `redirect`/`flush` may stay asserted across cycles. Exactly one training update and one count occur, on the cycle `ex_stall` falls.
- If reset is asserted mid-operation, all state clears immediately. A pending redirect is lost; the core restarts from the reset vector anyway.

## Structure
- `branch_pkg` provides:
  - `typedef enum logic [1:0] {SNT, WNT, WT, ST} bht_state_t`
  - `BHT_INIT = WNT`
  - `function bht_next(bht_state_t s, logic taken)`
- Sub-module `branch_sat_counter` is one 2-bit saturating counter. It has async reset to `BHT_INIT`, plus `clear`, `en` and `taken` inputs, and a `state` output. `branch_predict_unit` instantiates it ENTRIES times in a generate loop.
- Lookup mux, update decode, redirect logic and statistics live in the top module.

## Test plan
- **Reset check:** with ENTRIES=64, after reset `id_pc`=0x0..0xFC give `id_pred_taken`=0 throughout, and both counts are 0.
- **Training:** resolve `ex_pc`=0x40 as taken with `ex_pred_taken`=0.
  - Cycle 1: `redirect`=1 and `redirect_pc`=`ex_target`=0x80. Next cycle, `id_pc`=0x40 predicts 1 (WT).
  - Repeat taken twice, then not-taken once. The prediction stays 1 (ST→WT).
- **Aliasing:** train 0x100 to ST, then look up 0x200 (same index 0). Prediction is 1.
- **Correct not-taken:** `ex_taken`=0 with `ex_pred_taken`=0 gives `redirect`=0 and `redirect_pc`=`ex_pc`+4. With `ex_pc`=0xFFFFFFFC, `redirect_pc` wraps to 0x0.
- **Stall:** hold `ex_stall`=1 for 3 cycles on a mispredicted branch, then release.
  - `flush`=1 all 4 cycles.
  - `branch_count` +1 and `mispredict_count` +1 exactly once.
  - The entry moves one step.
- **Clear collision:** assert `bht_clear` in the same cycle as a taken resolve at index 5. Next cycle index 5 is WNT and both counts are 0.
